// File: rtl/apple1_pkg.sv
// Shared definitions for the Apple-1 PIA: the register window layout and the
// decoder that maps a CPU address onto one register.
package apple1_pkg;

    localparam logic [15:0] PIA_BASE_DEFAULT = 16'hD010;

    localparam logic [15:0] OFS_KBD   = 16'h0000;
    localparam logic [15:0] OFS_KBDCR = 16'h0001;
    localparam logic [15:0] OFS_DSP   = 16'h0002;
    localparam logic [15:0] OFS_DSPCR = 16'h0003;
    localparam logic [15:0] OFS_BIN   = 16'h0008;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_KBD,
        SEL_KBDCR,
        SEL_DSP,
        SEL_DSPCR,
        SEL_BIN
    } pia_sel_e;

    // Offset is taken modulo 2^16, so addresses below base never alias a register.
    function automatic pia_sel_e pia_decode(input logic [15:0] ab, input logic [15:0] base);
        logic [15:0] ofs;
        pia_sel_e    sel;
        ofs = ab - base;
        case (ofs)
            OFS_KBD:   sel = SEL_KBD;
            OFS_KBDCR: sel = SEL_KBDCR;
            OFS_DSP:   sel = SEL_DSP;
            OFS_DSPCR: sel = SEL_DSPCR;
            OFS_BIN:   sel = SEL_BIN;
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/apple1_pia_if.sv
// CPU-side bus of the PIA: address, write data and strobe from the core,
// registered read data and I/O request flag back to it.
interface apple1_pia_if;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [7:0]  DI_P;
    logic        IO_Req;

    modport master (
        output AB,
        output DO,
        output WE,
        input  DI_P,
        input  IO_Req
    );

    modport slave (
        input  AB,
        input  DO,
        input  WE,
        output DI_P,
        output IO_Req
    );
endinterface

// File: rtl/apple1_pia_fifo.sv
// Small synchronous FIFO used for the keyboard stream; push is refused when
// full and pop is ignored when empty, so callers may assert them freely.
module pia_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = 1;
    localparam logic [AW:0]    CNT_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage is not reset; an empty count is what discards stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apple1_pia.sv
// Apple-1 PIA replacement: keyboard FIFO, display output register and a
// binary-load byte port behind a five-register window on the CPU bus.
module apple1_pia
    import apple1_pkg::*;
#(
    parameter int          KBD_DEPTH = 4,
    parameter logic [15:0] BASE      = PIA_BASE_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    apple1_pia_if.slave         bus,
    input  logic [7:0]          kbd_data,
    input  logic                kbd_valid,
    output logic                kbd_ready,
    output logic [7:0]          dsp_data,
    output logic                dsp_valid,
    input  logic                dsp_ready,
    input  logic [7:0]          bin_data,
    input  logic                bin_valid,
    output logic                bin_ack
);

    pia_sel_e   sel;
    logic       hit;
    logic       rd;
    logic       wr;
    logic       fifo_full;
    logic       fifo_empty;
    logic       kbd_push;
    logic       kbd_pop;
    logic [7:0] kbd_head;
    logic [6:0] kbdcr;
    logic [7:0] dspcr;
    logic [7:0] rd_val;
    logic       dsp_wr;
    logic       dsp_accept;
    logic       dsp_drop;
    logic [7:0] drop_cnt;

    assign sel = pia_decode(bus.AB, BASE);
    assign hit = (sel != SEL_NONE);
    assign rd  = hit && !bus.WE;
    assign wr  = hit && bus.WE;

    assign kbd_ready = !fifo_full;
    assign kbd_push  = kbd_valid && kbd_ready;
    assign kbd_pop   = rd && (sel == SEL_KBD) && !fifo_empty;

    pia_fifo #(
        .DEPTH (KBD_DEPTH),
        .WIDTH (8)
    ) u_kbd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (kbd_push),
        .pop   (kbd_pop),
        .wdata (kbd_data),
        .rdata (kbd_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A byte pushed in the same cycle as a read of an empty FIFO is not visible yet.
    always_comb begin
        rd_val = 8'h00;
        case (sel)
            SEL_KBD:   rd_val = fifo_empty ? 8'h80 : (kbd_head | 8'h80);
            SEL_KBDCR: rd_val = {!fifo_empty, kbdcr};
            SEL_DSP:   rd_val = {dsp_valid, 7'b000_0000};
            SEL_DSPCR: rd_val = dspcr;
            SEL_BIN:   rd_val = bin_valid ? bin_data : 8'h00;
            default:   rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.DI_P   <= 8'h00;
            bus.IO_Req <= 1'b0;
            kbdcr      <= 7'h00;
            dspcr      <= 8'h00;
            bin_ack    <= 1'b0;
        end else begin
            bus.IO_Req <= hit;
            bin_ack    <= rd && (sel == SEL_BIN) && bin_valid;
            if (rd) begin
                bus.DI_P <= rd_val;
            end
            if (wr && (sel == SEL_KBDCR)) begin
                kbdcr <= bus.DO[6:0];
            end
            if (wr && (sel == SEL_DSPCR)) begin
                dspcr <= bus.DO;
            end
        end
    end

    // The display slot frees up in the same cycle the host takes the byte,
    // so a write landing on that handshake is accepted rather than dropped.
    assign dsp_wr     = wr && (sel == SEL_DSP);
    assign dsp_accept = dsp_wr && (!dsp_valid || dsp_ready);
    assign dsp_drop   = dsp_wr && dsp_valid && !dsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            dsp_data  <= 8'h00;
            dsp_valid <= 1'b0;
            drop_cnt  <= 8'h00;
        end else begin
            if (dsp_accept) begin
                dsp_data  <= bus.DO & 8'h7F;
                dsp_valid <= 1'b1;
            end else if (dsp_valid && dsp_ready) begin
                dsp_valid <= 1'b0;
            end
            if (dsp_drop && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/apple1_pia.md
APPLE1_PIA -- requirements
Module: apple1_pia

Interface
REQ-001 SHALL have parameter KBD_DEPTH, default 4, keyboard FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter BASE, default 16'hD010, base of PIA register window.
REQ-003 SHALL have ports: clk  in  1  single clock, same as CPU core clk.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 AB  in  16  CPU address bus.
REQ-006 DO  in  8  CPU write data.
REQ-007 WE  in  1  CPU write enable.
REQ-008 DI_P  out  8  registered peripheral read data, to CPU DI mux.
REQ-009 IO_Req  out  1  registered; high the cycle after AB hit a PIA address.
REQ-010 kbd_data  in  8, kbd_valid  in  1, kbd_ready  out  1  key stream from host, valid/ready.
REQ-011 dsp_data  out  8, dsp_valid  out  1, dsp_ready  in  1  display stream to host, valid/ready.
REQ-012 bin_data  in  8, bin_valid  in  1, bin_ack  out  1  binary-load byte stream.

Function
REQ-013 Decode: hit = AB in {BASE+0..BASE+3, BASE+8}; all other addresses no effect, DI_P holds.
REQ-014 Every clk edge with hit and !WE SHALL load DI_P with register value below (1-cycle read latency, matches synchronous memory).
REQ-015 KBD (BASE+0) read: DI_P = FIFO head | 8'h80; pops head if non-empty; empty returns 8'h80.
REQ-016 KBDCR (BASE+1) read: bit7 = FIFO non-empty, bits6:0 = kbdcr register.
REQ-017 DSP (BASE+2) read: bit7 = dsp_valid (busy), bits6:0 = 0.
REQ-018 DSPCR (BASE+3) read: dspcr register.
REQ-019 BIN (BASE+8) read: DI_P = bin_data if bin_valid else 8'h00; bin_ack pulses 1 cycle iff bin_valid.
REQ-020 Writes to KBDCR/DSPCR SHALL store DO[6:0]/DO[7:0]; writes to KBD/BIN ignored.
REQ-021 DSP write with dsp_valid=0: dsp_data <= DO & 8'h7F, dsp_valid <= 1 next cycle.
REQ-022 DSP write with dsp_valid=1: dropped, drop counter (8-bit, saturating, internal) increments.
REQ-023 dsp_valid clears on cycle after dsp_valid&&dsp_ready; a DSP write in that same cycle is accepted (new byte, valid stays 1).
REQ-024 kbd_ready = FIFO not full; push on kbd_valid&&kbd_ready.
REQ-025 Simultaneous push and pop SHALL both occur; count unchanged; pop on empty with push returns 8'h80 (not new byte).
REQ-026 FIFO pointers wrap modulo KBD_DEPTH; count width clog2(KBD_DEPTH)+1.
REQ-027 IO_Req = registered hit; DI_P remains valid until next hit read.

Reset
REQ-028 On reset: FIFO empty, kbdcr=0, dspcr=0, DI_P=0, IO_Req=0, dsp_valid=0, dsp_data=0, bin_ack=0, drop counter=0.
REQ-029 Reset mid-transfer SHALL discard pending display byte and FIFO contents with no output pulse.

Structure
REQ-030 Shared package apple1_pkg SHALL hold register offsets (KBD, KBDCR, DSP, DSPCR, BIN) and BASE default.
REQ-031 Keyboard FIFO SHALL be sub-module pia_fifo (parameterised depth/width, push/pop/full/empty).

Verification
REQ-032 Reset, then read D011 -> DI_P=8'h00 next cycle, IO_Req=1.
REQ-033 Push 'A' (8'h41) via kbd, read D011 then D010 -> 8'h80 then 8'hC1; D011 afterward -> 8'h00.
REQ-034 Push 5 keys with KBD_DEPTH=4 -> kbd_ready low after 4th; reads return first 4 in order.
REQ-035 Write 8'hC1 to D012 with dsp_ready=0 -> dsp_data=8'h41, dsp_valid=1; D012 read -> 8'h80; second write dropped; dsp_ready=1 -> dsp_valid=0.
REQ-036 bin_valid=1, bin_data=8'hA9, read D018 -> DI_P=8'hA9, one-cycle bin_ack; read AB=16'h0200 -> IO_Req=0, DI_P unchanged.
REQ-037 Simultaneous kbd push and D010 read on empty FIFO -> DI_P=8'h80, count=1.
